// File: rtl/neuraedge_pe_feeder.sv
// +--------------------------------------------------------------------------+
// | neuraedge_pe_feeder: per-command operand sequencer for one neuraedge PE.  |
// | Optional: NEURAEDGE_FEEDER_PERF_EN adds perf_stall_cnt. Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module neuraedge_pe_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_data,
    input  logic [WEIGHT_WIDTH-1:0] op_weight,
    output logic                    pe_enable,
    output logic                    mac_clear,
    output logic                    accumulate_en,
    output logic [DATA_WIDTH-1:0]   pe_data,
    output logic [WEIGHT_WIDTH-1:0] pe_weight,
    output logic                    pe_data_valid,
    input  logic [ACCUM_WIDTH-1:0]  pe_accum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACCUM_WIDTH-1:0]  res_data
`ifdef NEURAEDGE_FEEDER_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FEED   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic                    drain_q, drain_d;
    logic                    mac_clear_q, mac_clear_d;
    logic                    accumulate_en_q, accumulate_en_d;
    logic [DATA_WIDTH-1:0]   pe_data_q, pe_data_d;
    logic [WEIGHT_WIDTH-1:0] pe_weight_q, pe_weight_d;
    logic                    pe_data_valid_q, pe_data_valid_d;
    logic [ACCUM_WIDTH-1:0]  res_data_q, res_data_d;

    logic cmd_fire;
    logic op_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign op_fire  = op_valid & op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rem_q           <= '0;
            drain_q         <= 1'b0;
            mac_clear_q     <= 1'b0;
            accumulate_en_q <= 1'b0;
            pe_data_q       <= '0;
            pe_weight_q     <= '0;
            pe_data_valid_q <= 1'b0;
            res_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            drain_q         <= drain_d;
            mac_clear_q     <= mac_clear_d;
            accumulate_en_q <= accumulate_en_d;
            pe_data_q       <= pe_data_d;
            pe_weight_q     <= pe_weight_d;
            pe_data_valid_q <= pe_data_valid_d;
            res_data_q      <= res_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        drain_d         = drain_q;
        mac_clear_d     = 1'b0;
        accumulate_en_d = 1'b0;
        pe_data_valid_d = 1'b0;
        pe_data_d       = pe_data_q;
        pe_weight_d     = pe_weight_q;
        res_data_d      = res_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    rem_d       = cmd_len;
                    mac_clear_d = 1'b1;
                    drain_d     = 1'b0;
                    state_d     = (cmd_len == '0) ? ST_DRAIN : ST_FEED;
                end
            end
            ST_FEED: begin
                if (op_fire) begin
                    pe_data_d       = op_data;
                    pe_weight_d     = op_weight;
                    pe_data_valid_d = 1'b1;
                    accumulate_en_d = 1'b1;
                    rem_d           = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Second drain cycle: the last pair has been accumulated, pe_accum is final.
                if (drain_q) begin
                    res_data_d = pe_accum;
                    state_d    = ST_RESULT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        op_ready  = (state_q == ST_FEED) && (rem_q != '0);
        pe_enable = (state_q == ST_FEED) || (state_q == ST_DRAIN);
        res_valid = (state_q == ST_RESULT);
    end

    assign mac_clear     = mac_clear_q;
    assign accumulate_en = accumulate_en_q;
    assign pe_data       = pe_data_q;
    assign pe_weight     = pe_weight_q;
    assign pe_data_valid = pe_data_valid_q;
    assign res_data      = res_data_q;

`ifdef NEURAEDGE_FEEDER_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (cmd_fire) begin
            perf_stall_cnt_d = '0;
        end else if ((state_q == ST_FEED) && (rem_q != '0) && !op_valid
                     && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_neuraedge_pe_feeder.sv
// +--------------------------------------------------------------------------+
// | tb_neuraedge_pe_feeder: directed bench with a behavioural PE model.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_neuraedge_pe_feeder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_data;
    logic [7:0]  op_weight;
    logic        pe_enable;
    logic        mac_clear;
    logic        accumulate_en;
    logic [7:0]  pe_data;
    logic [7:0]  pe_weight;
    logic        pe_data_valid;
    logic [31:0] pe_accum;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
`ifdef NEURAEDGE_FEEDER_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs;
    int clr_cnt = 0;
    int pdv_cnt = 0;
    int clr_base;
    int pdv_base;

    neuraedge_pe_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_data       (op_data),
        .op_weight     (op_weight),
        .pe_enable     (pe_enable),
        .mac_clear     (mac_clear),
        .accumulate_en (accumulate_en),
        .pe_data       (pe_data),
        .pe_weight     (pe_weight),
        .pe_data_valid (pe_data_valid),
        .pe_accum      (pe_accum),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data)
`ifdef NEURAEDGE_FEEDER_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: clear wins, otherwise accumulate the signed product, wrapping.
    logic signed [15:0] pe_prod;
    assign pe_prod = $signed(pe_data) * $signed(pe_weight);

    initial pe_accum = 32'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_clear === 1'b1) clr_cnt <= clr_cnt + 1;
        if (pe_data_valid === 1'b1) pdv_cnt <= pdv_cnt + 1;
        if (pe_enable === 1'b1) begin
            if (mac_clear === 1'b1)
                pe_accum <= 32'd0;
            else if (accumulate_en === 1'b1 && pe_data_valid === 1'b1)
                pe_accum <= pe_accum + {{16{pe_prod[15]}}, pe_prod};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] len);
        int k;
        cmd_valid = 1'b1;
        cmd_len   = len;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("cmd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        last_hs   = cyc;
    endtask

    task automatic feed_pair(input logic [7:0] d, input logic [7:0] w, input bit bubble);
        int k;
        if (bubble) begin
            op_valid = 1'b0;
            @(negedge clk);
            chk("bubble_pdv", {31'd0, pe_data_valid}, 32'd0);
        end
        op_valid  = 1'b1;
        op_data   = d;
        op_weight = w;
        k = 0;
        while (op_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("op_timeout", 32'd0, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        last_hs  = cyc;
        chk("issue_pdv", {31'd0, pe_data_valid}, 32'd1);
        chk("issue_data", {24'd0, pe_data}, {24'd0, d});
    endtask

    // res_valid must appear in cycle t+3, i.e. two edges after the handshake edge.
    task automatic wait_res(input string tag);
        int k;
        int start;
        start = last_hs;
        k = 0;
        while (res_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_lat"}, 32'(cyc - start), 32'd2);
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_res_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_res_valid", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 16'd0;
        op_valid  = 1'b0;
        op_data   = 8'd0;
        op_weight = 8'd0;
        res_ready = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_pe_enable", {31'd0, pe_enable}, 32'd0);
        chk("rst_mac_clear", {31'd0, mac_clear}, 32'd0);
        chk("rst_pe_data", {15'd0, pe_data_valid, pe_data, pe_weight}, 32'd0);
        chk("rst_res", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);

        // K=4 back-to-back: 2+12-5-6 = 3
        clr_base = clr_cnt;
        send_cmd(16'd4);
        chk("k4_mac_clear", {31'd0, mac_clear}, 32'd1);
        chk("k4_pe_enable", {31'd0, pe_enable}, 32'd1);
        feed_pair(8'd1, 8'd2, 1'b0);
        feed_pair(8'd3, 8'd4, 1'b0);
        feed_pair(8'hFF, 8'd5, 1'b0);
        feed_pair(8'd2, 8'hFD, 1'b0);
        chk("k4_op_ready_drain", {31'd0, op_ready}, 32'd0);
        wait_res("k4");
        chk("k4_res_data", res_data, 32'd3);
        chk("k4_clr_pulses", 32'(clr_cnt - clr_base), 32'd1);
        chk("k4_pe_enable_res", {31'd0, pe_enable}, 32'd0);
        take_res();

        // K=0: clear only, result 0
        clr_base = clr_cnt;
        pdv_base = pdv_cnt;
        send_cmd(16'd0);
        chk("k0_mac_clear", {31'd0, mac_clear}, 32'd1);
        chk("k0_op_ready", {31'd0, op_ready}, 32'd0);
        wait_res("k0");
        chk("k0_res_data", res_data, 32'd0);
        chk("k0_clr_pulses", 32'(clr_cnt - clr_base), 32'd1);
        chk("k0_pdv_cnt", 32'(pdv_cnt - pdv_base), 32'd0);
        take_res();

        // K=3 with a bubble before each pair: 100+16384-10 = 16474
        send_cmd(16'd3);
        feed_pair(8'd10, 8'd10, 1'b1);
        feed_pair(8'h80, 8'h80, 1'b1);
        feed_pair(8'd5, 8'hFE, 1'b1);
        wait_res("k3");
        chk("k3_res_data", res_data, 32'd16474);
`ifdef NEURAEDGE_FEEDER_PERF_EN
        chk("k3_perf_stall", perf_stall_cnt, 32'd3);
`endif

        // Result back-pressure with a pending command
        cmd_valid = 1'b1;
        cmd_len   = 16'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data", res_data, 32'd16474);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        take_res();
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_cmd_taken", {31'd0, op_ready}, 32'd1);
        chk("bp_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);

        // Reset mid-FEED after two of four pairs
        feed_pair(8'd1, 8'd1, 1'b0);
        feed_pair(8'd1, 8'd1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("mid_rst_pdv", {31'd0, pe_data_valid}, 32'd0);
        chk("mid_rst_mac_clear", {31'd0, mac_clear}, 32'd0);
        chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);

        // K=1 after reset: 7 * -8 = -56
        clr_base = clr_cnt;
        send_cmd(16'd1);
        feed_pair(8'd7, 8'hF8, 1'b0);
        wait_res("k1");
        chk("k1_res_data", res_data, 32'hFFFF_FFC8);
        chk("k1_clr_pulses", 32'(clr_cnt - clr_base), 32'd1);
        take_res();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
